des_block_assembler: RTL and testbench

Byte-serial front end of the DES datapath. Packs an incoming byte stream into 64-bit plaintext blocks in DES bit order (bit 1 = MSB of first byte). Applies PKCS#5 padding at end of message and buffers up to two completed blocks. Its output port feeds the initial-permutation stage directly.

---
 rtl/des_block_assembler_if.sv | 22 ++
 rtl/des_block_assembler.sv | 138 +++++++++++++
 tb/tb_des_block_assembler.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/des_block_assembler_if.sv
// Byte-in / block-out handshake bundle
// for the DES block assembler.
interface des_block_assembler_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_last;
  logic        in_ready;
  logic [1:64] out_block;
  logic        out_valid;
  logic        out_last;
  logic        out_ready;

  modport master (
    output in_data, in_valid, in_last, out_ready,
    input  in_ready, out_block, out_valid, out_last
  );

  modport slave (
    input  in_data, in_valid, in_last, out_ready,
    output in_ready, out_block, out_valid, out_last
  );
endinterface

// File: rtl/des_block_assembler.sv
// Packs a byte stream into 64-bit DES blocks
// with optional PKCS#5 padding and a 2-deep buffer.
module des_block_assembler #(
  parameter bit PAD_EN = 1'b1
) (
  input logic clk,
  input logic rst,
  des_block_assembler_if.slave bus
);

  typedef enum logic {FILL, PADBLK} state_t;

  localparam logic [1:64] PAD_BLK = 64'h0808080808080808;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:64] asm_q, asm_d;
  logic [1:64] blk0_q, blk1_q;
  logic        last0_q, last1_q;
  logic [1:0]  fcnt_q;

  logic        acc;
  logic        pop;
  logic        push;
  logic [1:64] push_blk;
  logic        push_last;
  logic [1:64] fill_blk;
  logic [7:0]  pad;

  assign bus.in_ready  = (state_q == FILL) && (fcnt_q != 2'd2);
  assign bus.out_valid = (fcnt_q != 2'd0);
  assign bus.out_block = blk0_q;
  assign bus.out_last  = last0_q;

  assign acc = bus.in_valid && bus.in_ready;
  assign pop = bus.out_valid && bus.out_ready;

  // Merge the incoming byte, padding the tail on a last byte
  always_comb begin
    fill_blk = asm_q;
    pad      = PAD_EN ? {5'd0, 3'd7 - cnt_q} : 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (k == int'(cnt_q)) begin
        fill_blk[8*k+1 +: 8] = bus.in_data;
      end else if (k > int'(cnt_q) && bus.in_last) begin
        fill_blk[8*k+1 +: 8] = pad;
      end
    end
  end

  // Next state, byte counter and FIFO push request
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    push      = 1'b0;
    push_blk  = fill_blk;
    push_last = 1'b0;
    unique case (state_q)
      FILL: begin
        if (acc) begin
          if (bus.in_last) begin
            push  = 1'b1;
            cnt_d = 3'd0;
            if (cnt_q == 3'd7 && PAD_EN) begin
              state_d = PADBLK;
            end else begin
              push_last = 1'b1;
            end
          end else if (cnt_q == 3'd7) begin
            push  = 1'b1;
            cnt_d = 3'd0;
          end else begin
            asm_d = fill_blk;
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      PADBLK: begin
        if (fcnt_q != 2'd2) begin
          push      = 1'b1;
          push_blk  = PAD_BLK;
          push_last = 1'b1;
          state_d   = FILL;
        end
      end
      default: ;
    endcase
  end

  // Registered state, assembly and 2-entry shift FIFO
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FILL;
      cnt_q   <= 3'd0;
      asm_q   <= '0;
      blk0_q  <= '0;
      blk1_q  <= '0;
      last0_q <= 1'b0;
      last1_q <= 1'b0;
      fcnt_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      asm_q   <= asm_d;
      unique case ({push, pop})
        2'b10: begin
          fcnt_q <= fcnt_q + 2'd1;
          if (fcnt_q == 2'd0) begin
            blk0_q  <= push_blk;
            last0_q <= push_last;
          end else begin
            blk1_q  <= push_blk;
            last1_q <= push_last;
          end
        end
        2'b01: begin
          fcnt_q  <= fcnt_q - 2'd1;
          blk0_q  <= blk1_q;
          last0_q <= last1_q;
        end
        2'b11: begin
          if (fcnt_q == 2'd1) begin
            blk0_q  <= push_blk;
            last0_q <= push_last;
          end else begin
            blk0_q  <= blk1_q;
            last0_q <= last1_q;
            blk1_q  <= push_blk;
            last1_q <= push_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_des_block_assembler.sv
// Self-checking bench for des_block_assembler
// with a queue-based message/block model.
module tb_des_block_assembler;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  des_block_assembler_if b ();
  des_block_assembler_if b0 ();

  des_block_assembler #(.PAD_EN(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(b)
  );

  des_block_assembler #(.PAD_EN(1'b0)) dut0 (
    .clk(clk),
    .rst(rst),
    .bus(b0)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]  cur[$];
  logic [64:0] expq[$];
  bit          acc;
  bit          held_v;
  logic [64:0] held;
  logic [64:0] head;

  task automatic chk(string tag, logic [64:0] obs, logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pack();
    logic [63:0] v = '0;
    foreach (cur[i]) v = {v[55:0], cur[i]};
    return v;
  endfunction

  // Reference: PKCS#5 message framing into 8-byte blocks
  function automatic void model_byte(logic [7:0] d, logic last);
    int n;
    cur.push_back(d);
    if (last) begin
      n = cur.size();
      if (n < 8) begin
        while (cur.size() < 8) cur.push_back(8'(8 - n));
        expq.push_back({1'b1, pack()});
      end else begin
        expq.push_back({1'b0, pack()});
        expq.push_back({1'b1, 64'h0808080808080808});
      end
      cur.delete();
    end else if (cur.size() == 8) begin
      expq.push_back({1'b0, pack()});
      cur.delete();
    end
  endfunction

  task automatic step();
    @(negedge clk);
    acc = b.in_valid && b.in_ready && !rst;
    if (!rst) begin
      if (held_v && b.out_valid)
        chk("hold", {b.out_last, b.out_block}, held);
      if (b.out_valid && b.out_ready) begin
        chk("pop_expected", 65'(expq.size() != 0), 65'd1);
        if (expq.size() != 0) begin
          head = expq.pop_front();
          chk("pop_block", {b.out_last, b.out_block}, head);
        end
      end
      if (acc) model_byte(b.in_data, b.in_last);
      held_v = b.out_valid && !b.out_ready;
      held   = {b.out_last, b.out_block};
    end else begin
      held_v = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(logic [7:0] d, logic l);
    b.in_data  = d;
    b.in_valid = 1'b1;
    b.in_last  = l;
    for (int i = 0; i < 64; i++) begin
      step();
      if (acc) break;
    end
    if (!acc) chk("send_timeout", 65'd0, 65'd1);
    b.in_valid = 1'b0;
    b.in_last  = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent;
    rst          = 1'b1;
    held_v       = 1'b0;
    b.in_data    = '0;
    b.in_valid   = 1'b0;
    b.in_last    = 1'b0;
    b.out_ready  = 1'b0;
    b0.in_data   = '0;
    b0.in_valid  = 1'b0;
    b0.in_last   = 1'b0;
    b0.out_ready = 1'b1;
    @(posedge clk);
    #1;
    step();
    step();
    rst = 1'b0;
    chk("rst_out_valid", 65'(b.out_valid), 65'd0);
    chk("rst_out_last", 65'(b.out_last), 65'd0);
    chk("rst_out_block", 65'(b.out_block), 65'd0);
    chk("rst_in_ready", 65'(b.in_ready), 65'd1);

    // Plain 8-byte block
    b.out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) send(8'(i), 1'b0);
    chk("t1_valid", 65'(b.out_valid), 65'd1);
    chk("t1_head", {b.out_last, b.out_block},
        {1'b0, 64'h0102030405060708});
    step();
    chk("t1_valid_gone", 65'(b.out_valid), 65'd0);

    // Short padded message
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b0);
    send(8'hCC, 1'b1);
    chk("t2_head", {b.out_last, b.out_block},
        {1'b1, 64'hAABBCC0505050505});
    step();

    // Full block with pad-only block
    for (int i = 1; i <= 8; i++) send(8'(i * 8'h11), i == 8);
    chk("t3_padblk_ready", 65'(b.in_ready), 65'd0);
    chk("t3_head0", {b.out_last, b.out_block},
        {1'b0, 64'h1122334455667788});
    step();
    chk("t3_head1", {b.out_last, b.out_block},
        {1'b1, 64'h0808080808080808});
    chk("t3_ready_back", 65'(b.in_ready), 65'd1);
    step();
    chk("t3_empty", 65'(b.out_valid), 65'd0);

    // Back-pressure: 24 bytes at full rate
    b.out_ready = 1'b0;
    sent = 0;
    for (int c = 0; c < 24; c++) begin
      b.in_data  = 8'(8'h30 + sent);
      b.in_valid = 1'b1;
      b.in_last  = 1'b0;
      step();
      if (acc) sent++;
    end
    chk("bp_accepted", 65'(sent), 65'd16);
    chk("bp_in_ready", 65'(b.in_ready), 65'd0);
    b.out_ready = 1'b1;
    for (int c = 0; c < 64 && sent < 24; c++) begin
      b.in_data = 8'(8'h30 + sent);
      step();
      if (acc) sent++;
    end
    b.in_valid = 1'b0;
    repeat (4) step();
    chk("bp_all_sent", 65'(sent), 65'd24);
    chk("bp_drained", 65'(expq.size()), 65'd0);
    chk("bp_empty", 65'(b.out_valid), 65'd0);

    // Reset with one block buffered and 5 in assembly
    b.out_ready = 1'b0;
    for (int i = 0; i < 13; i++) send(8'(8'h50 + i), 1'b0);
    chk("r_pre_valid", 65'(b.out_valid), 65'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    cur.delete();
    expq.delete();
    chk("r_out_valid", 65'(b.out_valid), 65'd0);
    chk("r_in_ready", 65'(b.in_ready), 65'd1);
    b.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) send(8'(8'hA0 + i), 1'b0);
    chk("r_head", {b.out_last, b.out_block},
        {1'b0, 64'hA0A1A2A3A4A5A6A7});
    step();

    // Zero-fill variant
    chk("z_ready", 65'(b0.in_ready), 65'd1);
    b0.in_data  = 8'h11;
    b0.in_valid = 1'b1;
    step();
    b0.in_data = 8'h22;
    b0.in_last = 1'b1;
    step();
    b0.in_valid = 1'b0;
    b0.in_last  = 1'b0;
    chk("z_valid", 65'(b0.out_valid), 65'd1);
    chk("z_head", {b0.out_last, b0.out_block},
        {1'b1, 64'h1122000000000000});
    step();
    step();
    chk("z_no_extra", 65'(b0.out_valid), 65'd0);

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      b.in_valid  = ($urandom_range(0, 9) < 7);
      b.in_data   = 8'($urandom);
      b.in_last   = ($urandom_range(0, 9) == 0);
      b.out_ready = ($urandom_range(0, 9) < 6);
      step();
    end
    b.in_valid  = 1'b0;
    b.in_last   = 1'b0;
    b.out_ready = 1'b1;
    repeat (8) step();
    chk("rnd_drained", 65'(expq.size()), 65'd0);
    chk("rnd_empty", 65'(b.out_valid), 65'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
